coin_acceptor: RTL and testbench



---
 rtl/coin_acceptor.sv | 210 +++++++++++++++++++++
 tb/tb_coin_acceptor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// coin_acceptor
//   Front end for the vending controller. It synchronises and debounces the
//   two raw coin sensors and turns each clean rising level into one queued
//   coin event. Queued events are replayed in order as single-cycle codes,
//   with a guaranteed idle gap between them.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   sense_small  raw small-coin sensor (asynchronous, active high)
//   sense_large  raw large-coin sensor (asynchronous, active high)
//   coin         2'b00 idle, 2'b01 small, 2'b10 large (2'b11 never driven)
//   jam          one-cycle pulse: both sensors produced an event in one cycle
//   overflow     sticky: an event was dropped because the queue was full
//   pending      number of events currently queued
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sense_small,
  input  logic                        sense_large,
  output logic [1:0]                  coin,
  output logic                        jam,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] pending
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] FULL_COUNT = PW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES);

  // Sensor vectors: bit 0 is the small-coin sensor, bit 1 the large-coin one.
  logic [1:0]    s1_r;
  logic [1:0]    s2_r;
  logic [1:0]    stable_r;
  logic [1:0]    stable_nxt_s;
  logic [1:0]    rise_s;
  logic [1:0]    ev_r;
  logic [CW-1:0] cnt_r     [2];
  logic [CW-1:0] cnt_nxt_s [2];

  logic          push_s;
  logic [1:0]    push_code_s;
  logic          jam_nxt_s;

  logic [1:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [PW-1:0] count_r;
  logic [PW-1:0] count_nxt_s;
  logic [GW-1:0] gap_r;
  logic [GW-1:0] gap_nxt_s;
  logic          pop_s;
  logic          full_s;
  logic          wr_en_s;
  logic          drop_s;
  logic [1:0]    coin_nxt_s;

  logic [1:0]    coin_r;
  logic          jam_r;
  logic          overflow_r;

  // Two-flop synchronisers for both raw sensor lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r <= 2'b00;
      s2_r <= 2'b00;
    end else begin
      s1_r <= {sense_large, sense_small};
      s2_r <= s1_r;
    end
  end

  // Debounce next state: the stable level only follows s2 after it has
  // differed for DEBOUNCE_CYCLES consecutive cycles; only 0->1 flags an event.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stable_nxt_s[i] = stable_r[i];
      cnt_nxt_s[i]    = {CW{1'b0}};
      rise_s[i]       = 1'b0;
      if (s2_r[i] == stable_r[i]) begin
        cnt_nxt_s[i] = {CW{1'b0}};
      end else if (cnt_r[i] == CNT_LAST) begin
        stable_nxt_s[i] = s2_r[i];
        rise_s[i]       = s2_r[i];
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CW'(1);
      end
    end
  end

  // Debounce state and one-cycle event flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_r <= 2'b00;
      cnt_r[0] <= {CW{1'b0}};
      cnt_r[1] <= {CW{1'b0}};
      ev_r     <= 2'b00;
    end else begin
      stable_r <= stable_nxt_s;
      cnt_r[0] <= cnt_nxt_s[0];
      cnt_r[1] <= cnt_nxt_s[1];
      ev_r     <= rise_s;
    end
  end

  // Classify this cycle's events: a lone event is queued, a simultaneous
  // pair is ambiguous and reported as a jam instead.
  always_comb begin
    push_s      = 1'b0;
    push_code_s = 2'b00;
    jam_nxt_s   = 1'b0;
    case (ev_r)
      2'b01: begin
        push_s      = 1'b1;
        push_code_s = 2'b01;
      end
      2'b10: begin
        push_s      = 1'b1;
        push_code_s = 2'b10;
      end
      2'b11: begin
        jam_nxt_s = 1'b1;
      end
      default: begin
        push_s      = 1'b0;
        push_code_s = 2'b00;
        jam_nxt_s   = 1'b0;
      end
    endcase
  end

  // Queue and sequencer control. A pop frees its slot in the same cycle, so
  // a push into a full queue still succeeds when a pop happens alongside it.
  always_comb begin
    pop_s   = (count_r != {PW{1'b0}}) && (gap_r == {GW{1'b0}});
    full_s  = (count_r == FULL_COUNT);
    wr_en_s = push_s && (!full_s || pop_s);
    drop_s  = push_s && full_s && !pop_s;

    case ({wr_en_s, pop_s})
      2'b10:   count_nxt_s = count_r + PW'(1);
      2'b01:   count_nxt_s = count_r - PW'(1);
      default: count_nxt_s = count_r;
    endcase

    // The gap counter is reloaded by a pop and then runs down on the idle
    // cycles that follow, blocking the next pop until it reaches zero.
    if (pop_s) begin
      gap_nxt_s = GAP_LOAD;
    end else if (gap_r != {GW{1'b0}}) begin
      gap_nxt_s = gap_r - GW'(1);
    end else begin
      gap_nxt_s = gap_r;
    end

    if (pop_s) begin
      coin_nxt_s = mem_r[rd_ptr_r];
    end else begin
      coin_nxt_s = 2'b00;
    end
  end

  // Queue storage, pointers, gap counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 2'b00;
      end
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {PW{1'b0}};
      gap_r      <= {GW{1'b0}};
      coin_r     <= 2'b00;
      jam_r      <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_code_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r    <= count_nxt_s;
      gap_r      <= gap_nxt_s;
      coin_r     <= coin_nxt_s;
      jam_r      <= jam_nxt_s;
      overflow_r <= overflow_r | drop_s;
    end
  end

  assign coin     = coin_r;
  assign jam      = jam_r;
  assign overflow = overflow_r;
  assign pending  = count_r;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor. Two instances share clock and reset: instance 0
// uses the default parameters, instance 1 uses a short debounce and a long
// gap so that the queue can be driven into overflow. A reference model
// works from the behavioural rules (sample history, a plain code queue)
// and is compared against both instances after every clock edge.
module tb_coin_acceptor;

  localparam int DB0   = 4;
  localparam int DB1   = 2;
  localparam int GP0   = 1;
  localparam int GP1   = 10;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       ss [2];
  logic       sl [2];
  logic [1:0] coin_w [2];
  logic       jam_w  [2];
  logic       ovf_w  [2];
  logic [2:0] pend_w [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  coin_acceptor #(.DEBOUNCE_CYCLES(DB0), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GP0)) dut0 (
    .clk(clk), .rst(rst), .sense_small(ss[0]), .sense_large(sl[0]),
    .coin(coin_w[0]), .jam(jam_w[0]), .overflow(ovf_w[0]), .pending(pend_w[0])
  );

  coin_acceptor #(.DEBOUNCE_CYCLES(DB1), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GP1)) dut1 (
    .clk(clk), .rst(rst), .sense_small(ss[1]), .sense_large(sl[1]),
    .coin(coin_w[1]), .jam(jam_w[1]), .overflow(ovf_w[1]), .pending(pend_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int        dcyc [2] = '{DB0, DB1};
  int        gapc [2] = '{GP0, GP1};
  bit [15:0] hist [2][2];     // synchronised samples seen, newest in bit 0
  bit [1:0]  m_s1 [2];
  bit [1:0]  m_s2 [2];
  bit [1:0]  m_stable [2];
  bit [1:0]  m_ev [2];
  bit [1:0]  m_q [2][DEPTH];
  int        m_qn [2];
  int        m_gap [2];
  bit [1:0]  m_coin [2];
  bit        m_jam [2];
  bit        m_ovf [2];

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      hist[k][0] = 16'h0000;
      hist[k][1] = 16'h0000;
      m_s1[k] = 2'b00; m_s2[k] = 2'b00; m_stable[k] = 2'b00; m_ev[k] = 2'b00;
      m_qn[k] = 0; m_gap[k] = 0; m_coin[k] = 2'b00; m_jam[k] = 1'b0; m_ovf[k] = 1'b0;
      for (int j = 0; j < DEPTH; j++) m_q[k][j] = 2'b00;
    end
  endtask

  // One clock edge of instance k with the raw inputs {large, small}.
  task automatic model_edge(input int k, input bit [1:0] raw);
    bit [1:0]  old_ev;
    bit [1:0]  new_ev;
    bit [15:0] mask;
    bit [15:0] want;
    old_ev = m_ev[k];
    new_ev = 2'b00;
    mask   = 16'((32'd1 << dcyc[k]) - 32'd1);
    // A level is accepted once the last dcyc samples all disagree with it.
    for (int i = 0; i < 2; i++) begin
      hist[k][i] = {hist[k][i][14:0], m_s2[k][i]};
      want = m_stable[k][i] ? 16'h0000 : mask;
      if ((hist[k][i] & mask) == want) begin
        m_stable[k][i] = ~m_stable[k][i];
        new_ev[i] = m_stable[k][i];
      end
    end
    m_s2[k] = m_s1[k];
    m_s1[k] = raw;
    // Output sequencing: head of queue goes out when the gap has elapsed.
    if (m_qn[k] > 0 && m_gap[k] == 0) begin
      m_coin[k] = m_q[k][0];
      for (int j = 0; j < DEPTH - 1; j++) m_q[k][j] = m_q[k][j+1];
      m_qn[k]--;
      m_gap[k] = gapc[k];
    end else begin
      m_coin[k] = 2'b00;
      if (m_gap[k] > 0) m_gap[k]--;
    end
    m_jam[k] = (old_ev == 2'b11);
    if (old_ev == 2'b01 || old_ev == 2'b10) begin
      if (m_qn[k] < DEPTH) begin
        m_q[k][m_qn[k]] = (old_ev == 2'b01) ? 2'b01 : 2'b10;
        m_qn[k]++;
      end else begin
        m_ovf[k] = 1'b1;
      end
    end
    m_ev[k] = new_ev;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("coin%0d", k), {6'b000000, coin_w[k]}, {6'b000000, m_coin[k]});
      check($sformatf("jam%0d", k), {7'b0000000, jam_w[k]}, {7'b0000000, m_jam[k]});
      check($sformatf("overflow%0d", k), {7'b0000000, ovf_w[k]}, {7'b0000000, m_ovf[k]});
      check($sformatf("pending%0d", k), {5'b00000, pend_w[k]}, 8'(m_qn[k]));
    end
  endtask

  // Apply inputs, take one edge, advance the model, compare 1 time unit later.
  task automatic tick(input bit a0, input bit b0, input bit a1, input bit b1);
    ss[0] = a0; sl[0] = b0; ss[1] = a1; sl[1] = b1;
    @(posedge clk);
    model_edge(0, {b0, a0});
    model_edge(1, {b1, a1});
    cyc++;
    #1;
    compare_all();
  endtask

  // Asynchronous reset between edges, held across one edge.
  task automatic rst_pulse();
    #2;
    rst = 1'b1;
    ss[0] = 1'b0; sl[0] = 1'b0; ss[1] = 1'b0; sl[1] = 1'b0;
    #1;
    m_reset();
    compare_all();
    check("rst_pend_now", {5'b00000, pend_w[1]}, 8'd0);
    check("rst_ovf_now", {7'b0000000, ovf_w[1]}, 8'd0);
    @(posedge clk);
    #1;
    compare_all();
    #2;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int       n0;
  bit [1:0] got [$];
  int       hold [2][2];
  bit       lvl [2][2];

  initial begin
    rst = 1'b0;
    ss[0] = 1'b0; sl[0] = 1'b0; ss[1] = 1'b0; sl[1] = 1'b0;
    m_reset();

    // Reset then idle.
    #4 rst = 1'b1;
    #2;
    compare_all();
    #2 rst = 1'b0;
    for (int j = 0; j < 6; j++) tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Single small coin: pulse only after edge N+7.
    n0 = cyc + 1;
    for (int j = 0; j < 14; j++) begin
      tick(j < 10, 1'b0, 1'b0, 1'b0);
      check("small_lat", {6'b000000, coin_w[0]}, (cyc == n0 + 7) ? 8'h01 : 8'h00);
    end
    for (int j = 0; j < 10; j++) tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Single large coin.
    n0 = cyc + 1;
    for (int j = 0; j < 14; j++) begin
      tick(1'b0, j < 10, 1'b0, 1'b0);
      check("large_lat", {6'b000000, coin_w[0]}, (cyc == n0 + 7) ? 8'h02 : 8'h00);
    end
    for (int j = 0; j < 10; j++) tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Glitch of 3 cycles is rejected.
    for (int j = 0; j < 14; j++) begin
      tick(j < 3, 1'b0, 1'b0, 1'b0);
      check("glitch_coin", {6'b000000, coin_w[0]}, 8'h00);
      check("glitch_pend", {5'b00000, pend_w[0]}, 8'h00);
      check("glitch_jam", {7'b0000000, jam_w[0]}, 8'h00);
    end

    // Back-to-back small then large: 01, 00, 10 on consecutive cycles.
    n0 = cyc + 1;
    for (int j = 0; j < 14; j++) begin
      tick(1'b1, j >= 1, 1'b0, 1'b0);
      check("burst_seq", {6'b000000, coin_w[0]},
            (cyc == n0 + 7) ? 8'h01 : ((cyc == n0 + 9) ? 8'h02 : 8'h00));
    end
    for (int j = 0; j < 12; j++) tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Jam: both rise together, jam one cycle ahead of where a coin would be.
    n0 = cyc + 1;
    for (int j = 0; j < 14; j++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      check("jam_pulse", {7'b0000000, jam_w[0]}, (cyc == n0 + 6) ? 8'h01 : 8'h00);
      check("jam_coin", {6'b000000, coin_w[0]}, 8'h00);
      check("jam_pend", {5'b00000, pend_w[0]}, 8'h00);
    end
    for (int j = 0; j < 12; j++) tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Overflow on instance 1: alternate sensors faster than the gap drains.
    for (int j = 0; j < 12; j++) begin
      tick(1'b0, 1'b0, (j % 4) < 2, (j % 4) >= 2);
      if (coin_w[1] != 2'b00) got.push_back(coin_w[1]);
    end
    for (int j = 0; j < 60 && got.size() < 2; j++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      if (coin_w[1] != 2'b00) got.push_back(coin_w[1]);
    end
    check("ovf_ncodes", 8'(got.size()), 8'd2);
    check("ovf_code0", {6'b000000, (got.size() > 0) ? got[0] : 2'b00}, 8'h01);
    check("ovf_code1", {6'b000000, (got.size() > 1) ? got[1] : 2'b00}, 8'h02);
    check("ovf_sticky", {7'b0000000, ovf_w[1]}, 8'h01);
    check("ovf_pend_busy", {7'b0000000, pend_w[1] != 3'd0}, 8'h01);

    // Reset with events still queued discards them.
    rst_pulse();
    for (int j = 0; j < 30; j++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("post_rst_coin", {6'b000000, coin_w[1]}, 8'h00);
    end

    // Randomised sensor waveforms against the model.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) begin
        hold[k][i] = 0;
        lvl[k][i]  = 1'b0;
      end
    end
    for (int t = 0; t < 700; t++) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 2; i++) begin
          if (hold[k][i] == 0) begin
            lvl[k][i]  = 1'($urandom_range(0, 1));
            hold[k][i] = int'($urandom_range(1, 10));
          end
          hold[k][i]--;
        end
      end
      tick(lvl[0][0], lvl[0][1], lvl[1][0], lvl[1][1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
